// File: rtl/dma_xfer_engine_if.sv
// Control and memory-port bundle for the DMA transfer engine.
// Latency: wiring only. Backpressure: bus grant (ack) pauses the engine between words.
// master = engine side (drives hold/status/addresses/write strobes); slave = CPU/arbiter/memory side.
interface dma_xfer_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  // control registers and arbiter
  logic              start;
  logic              dir;        // 0: RAM -> disk, 1: disk -> RAM
  logic [ADDR_W-1:0] ram_base;
  logic [ADDR_W-1:0] disk_base;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic              ack;
  logic              hold;
  logic              busy;
  logic              done;
  logic              aborted;
  // RAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  // disk port
  logic [ADDR_W-1:0] disk_addr;
  logic [DATA_W-1:0] disk_wdata;
  logic              disk_we;
  logic [DATA_W-1:0] disk_rdata;

  modport master (
    input  start, dir, ram_base, disk_base, length, abort, ack, ram_rdata, disk_rdata,
    output hold, busy, done, aborted, ram_addr, ram_wdata, ram_we, disk_addr, disk_wdata, disk_we
  );

  modport slave (
    output start, dir, ram_base, disk_base, length, abort, ack, ram_rdata, disk_rdata,
    input  hold, busy, done, aborted, ram_addr, ram_wdata, ram_we, disk_addr, disk_wdata, disk_we
  );
endinterface

// File: rtl/dma_xfer_engine.sv
// Single-channel DMA engine: copies `length` words RAM<->disk at ascending addresses.
// Latency: 2 cycles/word (READ, WRITE) + 1 REQ cycle + 1 DONE cycle; zero length -> done next cycle.
// Backpressure: ack low at a READ parks the engine in REQ (hold kept high) until the grant returns.
//
// Ports: clock_i, reset_n_i (async, active low); bus (dma_xfer_engine_if.master) carries
//   start/dir/ram_base/disk_base/length/abort/ack in, hold/busy/done/aborted out, and the
//   RAM and disk ports (addr/wdata/we out, rdata in, rdata one cycle after addr).
// Optional feature macro: DMA_ABORT_EN (abort input cancels an active transfer).
module dma_xfer_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  dma_xfer_engine_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              dir_q;
  logic [ADDR_W-1:0] ram_base_q;
  logic [ADDR_W-1:0] disk_base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic              hold_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W-1:0] disk_addr_q;
  logic              ram_we_q;
  logic              disk_we_q;

  // Word index the next registered address refers to: leaving WRITE the
  // index advances in the same edge, so the following READ must use idx+1.
  logic [LEN_W-1:0]  idx_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [ADDR_W-1:0] disk_addr_d;
  logic              abort_hit;

  always_comb begin
    idx_d       = (state_q == S_WRITE) ? idx_q + LEN_W'(1) : idx_q;
    ram_addr_d  = ram_base_q + ADDR_W'(idx_d);
    disk_addr_d = disk_base_q + ADDR_W'(idx_d);
  end

`ifdef DMA_ABORT_EN
  assign abort_hit = bus.abort &&
                     ((state_q == S_REQ) || (state_q == S_READ) || (state_q == S_WRITE));
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_hit    = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      ram_base_q  <= '0;
      disk_base_q <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      ram_addr_q  <= '0;
      disk_addr_q <= '0;
      ram_we_q    <= 1'b0;
      disk_we_q   <= 1'b0;
    end else begin
      // pulses and write strobes default low every cycle
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ram_we_q  <= 1'b0;
      disk_we_q <= 1'b0;
      if (abort_hit) begin
        state_q   <= S_IDLE;
        hold_q    <= 1'b0;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              dir_q       <= bus.dir;
              ram_base_q  <= bus.ram_base;
              disk_base_q <= bus.disk_base;
              len_q       <= bus.length;
              idx_q       <= '0;
              busy_q      <= 1'b1;
              if (bus.length == '0) begin
                // nothing to move: complete without ever requesting the bus
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_REQ;
                hold_q  <= 1'b1;
              end
            end
          end
          S_REQ: begin
            if (bus.ack) begin
              state_q <= S_READ;
              if (dir_q) disk_addr_q <= disk_addr_d;
              else       ram_addr_q  <= ram_addr_d;
            end
          end
          S_READ: begin
            if (!bus.ack) begin
              // grant withdrawn: this read is discarded and redone after REQ
              state_q <= S_REQ;
            end else begin
              state_q <= S_WRITE;
              if (dir_q) begin
                ram_addr_q <= ram_addr_d;
                ram_we_q   <= 1'b1;
              end else begin
                disk_addr_q <= disk_addr_d;
                disk_we_q   <= 1'b1;
              end
            end
          end
          S_WRITE: begin
            idx_q <= idx_d;
            if (idx_d == len_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_READ;
              if (dir_q) disk_addr_q <= disk_addr_d;
              else       ram_addr_q  <= ram_addr_d;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.hold      = hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.disk_addr = disk_addr_q;
  // an abort seen during WRITE must kill the strobe already registered for this cycle
  assign bus.ram_we    = ram_we_q & ~abort_hit;
  assign bus.disk_we   = disk_we_q & ~abort_hit;
  // read data is passed straight through to the destination during WRITE
  assign bus.ram_wdata  = (state_q == S_WRITE && dir_q)  ? bus.disk_rdata : '0;
  assign bus.disk_wdata = (state_q == S_WRITE && !dir_q) ? bus.ram_rdata  : '0;

endmodule
